// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: occupancy encoding and stall counter width.
package pipe_pkg;

   localparam int STALL_W = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

endpackage

// File: rtl/pipe_entry.sv
// One held pipeline entry. Clear zeroes only the control half so a squashed slot
// can never carry a write enable, while the data half keeps its last value.
module pipe_entry #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CTRL_W-1:0] i_ctrl,
   output logic [DATA_W-1:0] o_data,
   output logic [CTRL_W-1:0] o_ctrl
);

   logic [DATA_W-1:0] r_data;
   logic [CTRL_W-1:0] r_ctrl;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
         r_ctrl <= '0;
      end else if (i_clear) begin
         r_ctrl <= '0;
      end else if (i_load) begin
         r_data <= i_data;
         r_ctrl <= i_ctrl;
      end
   end

   assign o_data = r_data;
   assign o_ctrl = r_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage: two-entry skid buffer (SKID=1, registered in_ready)
// or single entry with pass-through ready (SKID=0), plus a saturating stall counter.
//
//   state    | meaning
//   ST_EMPTY | no entry held
//   ST_ONE   | main entry valid
//   ST_TWO   | main and skid entries valid (SKID=1 only)
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 12,
   parameter int SKID   = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [CTRL_W-1:0]  in_ctrl,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [CTRL_W-1:0]  out_ctrl,
   output logic [STALL_W-1:0] stall_cnt
);

   state_t               r_state;
   state_t               w_state_nx;
   logic                 r_in_ready;
   logic                 r_live;
   logic [STALL_W-1:0]   r_stall_cnt;

   logic                 w_in_ready;
   logic                 w_out_valid;
   logic                 w_accept;
   logic                 w_release;
   logic                 w_main_load;
   logic                 w_main_from_skid;
   logic                 w_skid_load;
   logic [DATA_W-1:0]    w_main_d;
   logic [CTRL_W-1:0]    w_main_c;
   logic [DATA_W-1:0]    w_main_q_d;
   logic [CTRL_W-1:0]    w_main_q_c;
   logic [DATA_W-1:0]    w_skid_q_d;
   logic [CTRL_W-1:0]    w_skid_q_c;

   // r_live keeps the SKID=0 ready low for the cycle following a reset edge.
   assign w_out_valid = (r_state != ST_EMPTY);
   assign w_in_ready  = (SKID != 0) ? r_in_ready
                                    : (r_live && (!w_out_valid || out_ready));
   assign w_accept    = in_valid && w_in_ready;
   assign w_release   = w_out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b0;
         r_live     <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_in_ready <= (w_state_nx != ST_TWO);
         r_live     <= 1'b1;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      if (flush) begin
         w_state_nx = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: if (w_accept) w_state_nx = ST_ONE;
            ST_ONE: begin
               if (w_accept && !w_release)      w_state_nx = ST_TWO;
               else if (!w_accept && w_release) w_state_nx = ST_EMPTY;
            end
            ST_TWO:   if (w_release) w_state_nx = ST_ONE;
            default:  w_state_nx = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      w_main_load      = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_load      = 1'b0;
      if (!flush) begin
         case (r_state)
            ST_EMPTY: w_main_load = w_accept;
            ST_ONE: begin
               if (w_accept && w_release) w_main_load = 1'b1;
               else if (w_accept)         w_skid_load = 1'b1;
            end
            ST_TWO: begin
               w_main_load      = w_release;
               w_main_from_skid = w_release;
            end
            default: w_main_load = 1'b0;
         endcase
      end
   end

   assign w_main_d = w_main_from_skid ? w_skid_q_d : in_data;
   assign w_main_c = w_main_from_skid ? w_skid_q_c : in_ctrl;

   pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) main (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_main_load),
      .i_clear (flush),
      .i_data  (w_main_d),
      .i_ctrl  (w_main_c),
      .o_data  (w_main_q_d),
      .o_ctrl  (w_main_q_c)
   );

   pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) skid (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_skid_load),
      .i_clear (flush),
      .i_data  (in_data),
      .i_ctrl  (in_ctrl),
      .o_data  (w_skid_q_d),
      .o_ctrl  (w_skid_q_c)
   );

   always_ff @(posedge clk) begin
      if (rst)
         r_stall_cnt <= '0;
      else if (w_out_valid && !out_ready && (r_stall_cnt != {STALL_W{1'b1}}))
         r_stall_cnt <= r_stall_cnt + 1'b1;
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign out_data  = w_main_q_d;
   assign out_ctrl  = w_out_valid ? w_main_q_c : '0;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a SKID=1 instance driven from a vector table
// and hand sequences, plus a SKID=0 instance for the pass-through ready variant.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush, in_valid, out_ready;
   logic [31:0] in_data;
   logic [11:0] in_ctrl;
   logic        in_ready, out_valid;
   logic [31:0] out_data;
   logic [11:0] out_ctrl;
   logic [15:0] stall_cnt;

   logic        flush0, in_valid0, out_ready0;
   logic [31:0] in_data0;
   logic [11:0] in_ctrl0;
   logic        in_ready0, out_valid0;
   logic [31:0] out_data0;
   logic [11:0] out_ctrl0;
   logic [15:0] stall_cnt0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(12), .SKID(1)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
      .stall_cnt(stall_cnt)
   );

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(12), .SKID(0)) u_dut0 (
      .clk(clk), .rst(rst), .flush(flush0),
      .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_ctrl(in_ctrl0),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_ctrl(out_ctrl0),
      .stall_cnt(stall_cnt0)
   );

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic [11:0] c;
      logic        ordy;
      logic        e_ov;
      logic [31:0] e_d;
      logic [11:0] e_c;
      logic        e_ir;
      logic [15:0] e_st;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // iv, d, c, out_ready | out_valid, out_data, out_ctrl, in_ready, stall_cnt
      vecs[0] = '{1'b1, 32'hA5, 12'h0F1, 1'b1, 1'b1, 32'hA5, 12'h0F1, 1'b1, 16'd0};
      vecs[1] = '{1'b0, 32'h0,  12'h000, 1'b1, 1'b0, 32'hA5, 12'h000, 1'b1, 16'd0};
      vecs[2] = '{1'b1, 32'h1,  12'h801, 1'b0, 1'b1, 32'h1,  12'h801, 1'b1, 16'd0};
      vecs[3] = '{1'b1, 32'h2,  12'h802, 1'b0, 1'b1, 32'h1,  12'h801, 1'b0, 16'd1};
      vecs[4] = '{1'b1, 32'h3,  12'h803, 1'b0, 1'b1, 32'h1,  12'h801, 1'b0, 16'd2};
      vecs[5] = '{1'b1, 32'h3,  12'h803, 1'b1, 1'b1, 32'h2,  12'h802, 1'b1, 16'd2};
      vecs[6] = '{1'b1, 32'h3,  12'h803, 1'b1, 1'b1, 32'h3,  12'h803, 1'b1, 16'd2};
      vecs[7] = '{1'b1, 32'h4,  12'h804, 1'b1, 1'b1, 32'h4,  12'h804, 1'b1, 16'd2};
      vecs[8] = '{1'b0, 32'h0,  12'h000, 1'b1, 1'b0, 32'h4,  12'h000, 1'b1, 16'd2};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_ctrl = '0;
      flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0; in_data0 = '0; in_ctrl0 = '0;
      tick(); tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data",  out_data, 32'd0);
      chk("rst_out_ctrl",  {20'd0, out_ctrl}, 32'd0);
      chk("rst_stall",     {16'd0, stall_cnt}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
      chk("rst_in_ready0", {31'd0, in_ready0}, 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready",  {31'd0, in_ready}, 32'd1);
      chk("post_rst_in_ready0", {31'd0, in_ready0}, 32'd1);

      for (int i = 0; i < 9; i++) begin
         in_valid = vecs[i].iv; in_data = vecs[i].d; in_ctrl = vecs[i].c;
         out_ready = vecs[i].ordy;
         tick();
         chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
         chk($sformatf("v%0d_out_data", i),  out_data, vecs[i].e_d);
         chk($sformatf("v%0d_out_ctrl", i),  {20'd0, out_ctrl}, {20'd0, vecs[i].e_c});
         chk($sformatf("v%0d_in_ready", i),  {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
         chk($sformatf("v%0d_stall", i),     {16'd0, stall_cnt}, {16'd0, vecs[i].e_st});
      end

      // Fill to TWO, then flush while offering a new entry.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11; in_ctrl = 12'h111;
      tick();
      in_data = 32'h22; in_ctrl = 12'h222;
      tick();
      chk("two_in_ready", {31'd0, in_ready}, 32'd0);
      flush = 1'b1; in_data = 32'h33; in_ctrl = 12'h333;
      tick();
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_out_ctrl",  {20'd0, out_ctrl}, 32'd0);
      chk("flush_in_ready",  {31'd0, in_ready}, 32'd1);
      chk("flush_stall",     {16'd0, stall_cnt}, 32'd4);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("flush_discard", {31'd0, out_valid}, 32'd0);

      // SKID=0: continuous flow, then one cycle of backpressure.
      in_valid0 = 1'b1; out_ready0 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_data0 = 32'h100 + k; in_ctrl0 = 12'h400 + 12'(k);
         #1;
         chk($sformatf("s0_in_ready_%0d", k), {31'd0, in_ready0}, 32'd1);
         tick();
         chk($sformatf("s0_out_valid_%0d", k), {31'd0, out_valid0}, 32'd1);
         chk($sformatf("s0_out_data_%0d", k),  out_data0, 32'h100 + k);
         chk($sformatf("s0_out_ctrl_%0d", k),  {20'd0, out_ctrl0}, 32'h400 + k);
      end
      in_valid0 = 1'b0; out_ready0 = 1'b0;
      #1;
      chk("s0_bp_in_ready", {31'd0, in_ready0}, 32'd0);
      tick();
      chk("s0_bp_stall", {16'd0, stall_cnt0}, 32'd1);
      chk("s0_bp_hold",  out_data0, 32'h103);
      out_ready0 = 1'b1;
      #1;
      chk("s0_release_in_ready", {31'd0, in_ready0}, 32'd1);
      tick();
      chk("s0_drain_valid", {31'd0, out_valid0}, 32'd0);
      chk("s0_drain_ctrl",  {20'd0, out_ctrl0}, 32'd0);

      // Reset while in TWO.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h44; in_ctrl = 12'h444;
      tick();
      in_data = 32'h55; in_ctrl = 12'h555;
      tick();
      chk("pre_rst_stall", {16'd0, stall_cnt}, 32'd5);
      rst = 1'b1; in_valid = 1'b0;
      tick();
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_out_data",  out_data, 32'd0);
      chk("mid_rst_out_ctrl",  {20'd0, out_ctrl}, 32'd0);
      chk("mid_rst_stall",     {16'd0, stall_cnt}, 32'd0);
      chk("mid_rst_in_ready",  {31'd0, in_ready}, 32'd0);
      rst = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("no_stale_%0d", k), {31'd0, out_valid}, 32'd0);
      end
      chk("post_mid_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Long backpressure: counter must stop at all-ones.
      in_valid = 1'b1; in_data = 32'h66; in_ctrl = 12'h666; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      repeat (65534) @(posedge clk);
      #1;
      chk("stall_fffe", {16'd0, stall_cnt}, 32'h0000FFFE);
      tick();
      chk("stall_ffff", {16'd0, stall_cnt}, 32'h0000FFFF);
      repeat (4500) @(posedge clk);
      #1;
      chk("stall_sat",      {16'd0, stall_cnt}, 32'h0000FFFF);
      chk("stall_held_dat", out_data, 32'h66);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
